arith_issue_arbiter: RTL and testbench
======================================

ARITH_ISSUE_ARBITER -- requirements
Module: arith_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of reservation-station requesters sharing one arith unit.
REQ-002 Parameter TAG_W, default 4, ROB tag width.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 req_valid_i  input  NUM_REQ  requester i holds a ready-to-execute arith op.
REQ-006 req_grant_o  output  NUM_REQ  one-hot; requester i's op is accepted this cycle.
REQ-007 req_pc_i / req_inst_i / req_rs1_value_i / req_rs2_value_i  input  NUM_REQ x 32 each  per-requester operands.
REQ-008 req_tag_i  input  NUM_REQ x TAG_W  per-requester ROB tag.
REQ-009 arith_request_o  output  1  drives arith unit request.
REQ-010 arith_pc_o / arith_inst_o / arith_rs1_value_o / arith_rs2_value_o  output  32 each  operands of the granted requester.
REQ-011 arith_writeback_value_i  input  32  arith result, valid exactly 1 cycle after arith_request_o.
REQ-012 flush_i  input  1  pipeline flush; discards in-flight and buffered results.
REQ-013 wb_valid_o  output  1  result available for writeback bus.
REQ-014 wb_ready_i  input  1  writeback bus accepts result this cycle.
REQ-015 wb_tag_o  output  TAG_W  ROB tag of result; wb_value_o  output  32  result value.

Function
REQ-016 Grant SHALL be round-robin: search starts at rr_ptr, first req_valid_i set wins; at most one grant bit per cycle.
REQ-017 After a grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ; with no grant rr_ptr SHALL hold.
REQ-018 Grant SHALL be combinational from req_valid_i, rr_ptr and credit; arith_request_o SHALL equal OR of req_grant_o; arith_* operand outputs SHALL mux the granted requester's operands, and be 0 when no grant.
REQ-019 An issue SHALL set the in-flight register (valid, tag) at that edge; on the next edge the in-flight entry plus arith_writeback_value_i SHALL be pushed into a 2-entry result FIFO.
REQ-020 Credit: grant SHALL be allowed only when (FIFO occupancy + in-flight valid - pop this cycle) < 2, guaranteeing no result is ever dropped.
REQ-021 wb_valid_o/wb_tag_o/wb_value_o SHALL present the FIFO head; pop SHALL occur when wb_valid_o and wb_ready_i; tag/value 0 when empty.
REQ-022 Simultaneous push and pop on a full or 1-entry FIFO SHALL be legal; occupancy SHALL stay constant; FIFO pointers wrap mod 2.
REQ-023 Back-to-back issue every cycle SHALL be sustained while wb_ready_i is held high (throughput 1/cycle, issue-to-wb_valid latency 2 cycles).
REQ-024 flush_i SHALL, at the edge, clear in-flight valid and FIFO occupancy, and suppress all grants in the same cycle; rr_ptr SHALL be preserved.
REQ-025 Result order on wb SHALL equal issue order.

Reset
REQ-026 reset_i SHALL asynchronously clear rr_ptr to 0, in-flight valid, FIFO pointers and occupancy; all outputs SHALL read 0 during reset.
REQ-027 Reset asserted mid-operation SHALL discard in-flight and buffered results without emitting wb_valid_o.

Structure
REQ-028 Shared package arith_sched_pkg SHALL hold NUM_ARITH_REQ, ROB_TAG_W, ARITH_LATENCY (=1) and typedefs arith_req_t {pc, inst, rs1, rs2, tag} and arith_wb_t {tag, value}.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, ptr, enable; output one-hot grant).

Verification
REQ-030 Single request: req_valid_i=0001, inst 0x00518093, rs1 0x2, tag 3 -> grant 0001 same cycle; wb_valid_o 2 cycles later, wb_tag_o=3, wb_value_o=0x7.
REQ-031 All four valid continuously, wb_ready_i=1 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; tags returned in same order.
REQ-032 Backpressure: wb_ready_i=0 with continuous requests -> exactly 2 issues, then grants 0 until wb_ready_i=1; no result lost, order preserved.
REQ-033 flush_i pulse with one in-flight and one buffered result -> next cycle wb_valid_o=0, no grant in flush cycle, rr_ptr unchanged.
REQ-034 reset_i asserted asynchronously between edges with FIFO full -> outputs 0 immediately; after release first grant goes to requester 0.
REQ-035 Simultaneous pop and issue with FIFO at occupancy 1 -> occupancy remains 1, wb sequence continuous (wb_valid_o held high).

Source files
------------

// File: rtl/arith_sched_pkg.sv
// Shared scheduling constants and record types for the arith issue path.
package arith_sched_pkg;

  localparam int NUM_ARITH_REQ = 4;
  localparam int ROB_TAG_W     = 4;
  localparam int ARITH_LATENCY = 1;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          inst;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
    logic [ROB_TAG_W-1:0] tag;
  } arith_req_t;

  typedef struct packed {
    logic [ROB_TAG_W-1:0] tag;
    logic [31:0]          value;
  } arith_wb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester at or after ptr_i wins, one-hot out.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          enable_i,
  output logic [N-1:0]  grant_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk the requesters starting at the pointer, wrapping modulo N.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (enable_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arith_issue_arbiter.sv
// Issues one ready arith op per cycle from NUM_REQ requesters, tracks the
// single in-flight op and buffers results in a 2-entry FIFO for writeback.
module arith_issue_arbiter
  import arith_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_ARITH_REQ,
  parameter int TAG_W   = ROB_TAG_W
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  input  logic [NUM_REQ-1:0][31:0]      req_pc_i,
  input  logic [NUM_REQ-1:0][31:0]      req_inst_i,
  input  logic [NUM_REQ-1:0][31:0]      req_rs1_value_i,
  input  logic [NUM_REQ-1:0][31:0]      req_rs2_value_i,
  input  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag_i,
  output logic                          arith_request_o,
  output logic [31:0]                   arith_pc_o,
  output logic [31:0]                   arith_inst_o,
  output logic [31:0]                   arith_rs1_value_o,
  output logic [31:0]                   arith_rs2_value_o,
  input  logic [31:0]                   arith_writeback_value_i,
  input  logic                          flush_i,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [TAG_W-1:0]              wb_tag_o,
  output logic [31:0]                   wb_value_o
);

  localparam int PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      value;
  } wb_entry_t;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              inflight_valid_q, inflight_valid_d;
  logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  wb_entry_t         fifo_mem [FIFO_DEPTH];

  logic [NUM_REQ-1:0] grant;
  logic [TAG_W-1:0]   grant_tag;
  logic [2:0]         occ_after_pop;
  logic               credit_ok, grant_en, issue, push, pop;

  assign wb_valid_o = (count_q != 2'd0);
  assign pop        = wb_valid_o && wb_ready_i;
  assign push       = inflight_valid_q && !flush_i;

  // Only grant when the result slot is guaranteed: FIFO + in-flight, net of
  // this cycle's pop, must leave room. Reset gating keeps outputs quiet.
  assign occ_after_pop = 3'(count_q) + 3'(inflight_valid_q) - 3'(pop);
  assign credit_ok     = (occ_after_pop < 3'd2);
  assign grant_en      = credit_ok && !flush_i && !reset_i;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PTR_W)
  ) u_rr_arbiter (
    .req_i    (req_valid_i),
    .ptr_i    (rr_ptr_q),
    .enable_i (grant_en),
    .grant_o  (grant)
  );

  assign req_grant_o     = grant;
  assign issue           = |grant;
  assign arith_request_o = issue;

  // One-hot operand mux (all zero when nothing granted) and pointer advance.
  always_comb begin
    arith_pc_o        = '0;
    arith_inst_o      = '0;
    arith_rs1_value_o = '0;
    arith_rs2_value_o = '0;
    grant_tag         = '0;
    rr_ptr_d          = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        arith_pc_o        |= req_pc_i[i];
        arith_inst_o      |= req_inst_i[i];
        arith_rs1_value_o |= req_rs1_value_i[i];
        arith_rs2_value_o |= req_rs2_value_i[i];
        grant_tag         |= req_tag_i[i];
        rr_ptr_d           = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
  end

  // In-flight tracking and FIFO bookkeeping; flush drops everything pending.
  always_comb begin
    inflight_valid_d = issue;
    inflight_tag_d   = grant_tag;
    wr_ptr_d         = wr_ptr_q ^ push;
    rd_ptr_d         = rd_ptr_q ^ pop;
    count_d          = count_q + 2'(push) - 2'(pop);
    if (flush_i) begin
      inflight_valid_d = 1'b0;
      wr_ptr_d         = 1'b0;
      rd_ptr_d         = 1'b0;
      count_d          = 2'd0;
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q         <= '0;
      inflight_valid_q <= 1'b0;
      inflight_tag_q   <= '0;
      wr_ptr_q         <= 1'b0;
      rd_ptr_q         <= 1'b0;
      count_q          <= 2'd0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_tag_q   <= inflight_tag_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // Result storage; contents only matter while occupancy covers the slot.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {inflight_tag_q, arith_writeback_value_i};
    end
  end

  assign wb_tag_o   = wb_valid_o ? fifo_mem[rd_ptr_q].tag   : '0;
  assign wb_value_o = wb_valid_o ? fifo_mem[rd_ptr_q].value : '0;

endmodule

// File: tb/tb_arith_issue_arbiter.sv
// Directed bench for arith_issue_arbiter with a queue-based reference model.
module tb_arith_issue_arbiter;

  localparam int N  = 4;
  localparam int TW = 4;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b0;
  logic                   flush_i = 1'b0;
  logic                   wb_ready_i = 1'b0;
  logic [N-1:0]           req_valid_i;
  logic [N-1:0][31:0]     req_pc_i, req_inst_i, req_rs1_value_i, req_rs2_value_i;
  logic [N-1:0][TW-1:0]   req_tag_i;
  logic [31:0]            arith_writeback_value_i;
  logic [N-1:0]           req_grant_o;
  logic                   arith_request_o;
  logic [31:0]            arith_pc_o, arith_inst_o, arith_rs1_value_o, arith_rs2_value_o;
  logic                   wb_valid_o;
  logic [TW-1:0]          wb_tag_o;
  logic [31:0]            wb_value_o;

  int n_vec = 0;
  int n_err = 0;

  arith_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW)) dut (
    .clk_i                   (clk),
    .reset_i                 (reset_i),
    .req_valid_i             (req_valid_i),
    .req_grant_o             (req_grant_o),
    .req_pc_i                (req_pc_i),
    .req_inst_i              (req_inst_i),
    .req_rs1_value_i         (req_rs1_value_i),
    .req_rs2_value_i         (req_rs2_value_i),
    .req_tag_i               (req_tag_i),
    .arith_request_o         (arith_request_o),
    .arith_pc_o              (arith_pc_o),
    .arith_inst_o            (arith_inst_o),
    .arith_rs1_value_o       (arith_rs1_value_o),
    .arith_rs2_value_o       (arith_rs2_value_o),
    .arith_writeback_value_i (arith_writeback_value_i),
    .flush_i                 (flush_i),
    .wb_valid_o              (wb_valid_o),
    .wb_ready_i              (wb_ready_i),
    .wb_tag_o                (wb_tag_o),
    .wb_value_o              (wb_value_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // The arith unit behaves as addi: rs1 + sign-extended imm[31:20].
  function automatic logic [31:0] exec_addi(logic [31:0] inst, logic [31:0] rs1);
    return rs1 + {{20{inst[31]}}, inst[31:20]};
  endfunction

  // Reference model: results issued but not yet written back, in issue order.
  typedef struct {
    logic [TW-1:0] tag;
    logic [31:0]   value;
    int            ready;
  } res_t;

  res_t        mq[$];
  int          m_ptr = 0;
  int          m_cyc = 0;
  logic [31:0] m_pending_value = 32'h0;

  // Compare process: mid-cycle, check every output against the model, then advance it.
  always @(negedge clk) begin : cmp_proc
    logic          e_wb_valid, e_pop, found;
    logic [TW-1:0] e_tag;
    logic [31:0]   e_val, new_val;
    logic [1:0]    idx, gi;
    logic [3:0]    e_grant;
    res_t          r;
    if (reset_i) begin
      mq.delete();
      m_ptr = 0;
      check("rst_grant", 32'(req_grant_o), 32'h0);
      check("rst_request", 32'(arith_request_o), 32'h0);
      check("rst_pc", arith_pc_o, 32'h0);
      check("rst_wb_valid", 32'(wb_valid_o), 32'h0);
      check("rst_wb_tag", 32'(wb_tag_o), 32'h0);
      check("rst_wb_value", wb_value_o, 32'h0);
    end else begin
      e_wb_valid = (mq.size() > 0) && (mq[0].ready <= m_cyc);
      e_tag      = e_wb_valid ? mq[0].tag : '0;
      e_val      = e_wb_valid ? mq[0].value : 32'h0;
      e_pop      = e_wb_valid && wb_ready_i;
      found      = 1'b0;
      gi         = 2'd0;
      if (!flush_i && (mq.size() - (e_pop ? 1 : 0)) < 2) begin
        for (int k = 0; k < N; k++) begin
          idx = 2'((m_ptr + k) % N);
          if (!found && req_valid_i[idx]) begin
            found = 1'b1;
            gi    = idx;
          end
        end
      end
      e_grant = found ? (4'b0001 << gi) : 4'b0000;
      check("grant", 32'(req_grant_o), 32'(e_grant));
      check("request", 32'(arith_request_o), 32'(found));
      check("pc", arith_pc_o, found ? req_pc_i[gi] : 32'h0);
      check("inst", arith_inst_o, found ? req_inst_i[gi] : 32'h0);
      check("rs1", arith_rs1_value_o, found ? req_rs1_value_i[gi] : 32'h0);
      check("rs2", arith_rs2_value_o, found ? req_rs2_value_i[gi] : 32'h0);
      check("wb_valid", 32'(wb_valid_o), 32'(e_wb_valid));
      check("wb_tag", 32'(wb_tag_o), 32'(e_tag));
      check("wb_value", wb_value_o, e_val);
      new_val = exec_addi(req_inst_i[gi], req_rs1_value_i[gi]);
      if (flush_i) begin
        mq.delete();
      end else begin
        if (e_pop) void'(mq.pop_front());
        if (found) begin
          r.tag   = req_tag_i[gi];
          r.value = new_val;
          r.ready = m_cyc + 2;
          mq.push_back(r);
          m_ptr = (int'(gi) + 1) % N;
        end
      end
      m_pending_value = found ? new_val : (32'hBAD0_0000 ^ 32'(m_cyc));
    end
    m_cyc++;
  end

  // Advance one cycle; the arith result for last cycle's issue is presented now.
  task automatic tick();
    @(posedge clk);
    #1;
    arith_writeback_value_i = m_pending_value;
  endtask

  task automatic load_ops(int base);
    for (int i = 0; i < N; i++) begin
      req_pc_i[i]        = 32'h1000 + 32'(base * 16 + i * 4);
      req_inst_i[i]      = {12'(base + i + 1), 5'd3, 3'b000, 5'd1, 7'h13};
      req_rs1_value_i[i] = 32'(base * 256 + i);
      req_rs2_value_i[i] = 32'hA5A5_0000 + 32'(i);
      req_tag_i[i]       = TW'(base + i);
    end
  endtask

  int issues;

  initial begin
    req_valid_i = '0;
    load_ops(0);
    arith_writeback_value_i = 32'h0;

    // Reset with requests pending: nothing may be granted.
    #1 reset_i = 1'b1;
    req_valid_i = '1;
    wb_ready_i  = 1'b1;
    tick();
    #1;
    check("reset_grant_gated", 32'(req_grant_o), 32'h0);
    check("reset_wb_valid", 32'(wb_valid_o), 32'h0);
    tick();
    reset_i = 1'b0;

    // All four requesting, writeback always ready: 1/cycle, 2-cycle latency.
    for (int c = 0; c < 6; c++) begin
      load_ops(c * 4);
      req_valid_i = '1;
      #1;
      if (c < 5) check("stream_grant", 32'(req_grant_o), 32'(1 << (c % 4)));
      if (c >= 2) check("stream_wb_held", 32'(wb_valid_o), 32'h1);
      if (c == 2) begin
        check("stream_first_tag", 32'(wb_tag_o), 32'h0);
        check("stream_first_value", wb_value_o, 32'd1);
      end
      if (c == 3) begin
        check("stream_second_tag", 32'(wb_tag_o), 32'h5);
        check("stream_second_value", wb_value_o, 32'd1031);
      end
      tick();
    end
    req_valid_i = '0;
    repeat (3) tick();

    // Single request: addi x1,x3,5 with rs1=2 gives 7, tag 3.
    req_valid_i        = 4'b0001;
    req_inst_i[0]      = 32'h0051_8093;
    req_rs1_value_i[0] = 32'h2;
    req_tag_i[0]       = 4'd3;
    #1;
    check("single_grant", 32'(req_grant_o), 32'h1);
    check("single_inst", arith_inst_o, 32'h0051_8093);
    tick();
    req_valid_i = '0;
    #1 check("single_wb_early", 32'(wb_valid_o), 32'h0);
    tick();
    #1;
    check("single_wb_valid", 32'(wb_valid_o), 32'h1);
    check("single_wb_tag", 32'(wb_tag_o), 32'h3);
    check("single_wb_value", wb_value_o, 32'h7);
    tick();

    // Flush with one buffered and one in-flight result; pointer sits at 1.
    wb_ready_i  = 1'b0;
    req_valid_i = '1;
    load_ops(8);
    #1 check("flush_pre_grant_a", 32'(req_grant_o), 32'h2);
    tick();
    #1 check("flush_pre_grant_b", 32'(req_grant_o), 32'h4);
    tick();
    flush_i = 1'b1;
    #1;
    check("flush_cycle_grant", 32'(req_grant_o), 32'h0);
    check("flush_cycle_wb_valid", 32'(wb_valid_o), 32'h1);
    tick();
    flush_i    = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    check("post_flush_wb_valid", 32'(wb_valid_o), 32'h0);
    check("post_flush_grant", 32'(req_grant_o), 32'h8);
    tick();
    req_valid_i = '0;
    repeat (3) tick();

    // Backpressure: only two issues fit until writeback resumes.
    wb_ready_i  = 1'b0;
    req_valid_i = '1;
    issues = 0;
    for (int c = 0; c < 6; c++) begin
      load_ops(32 + c);
      #1;
      if (arith_request_o) issues++;
      tick();
    end
    check("bp_issue_count", 32'(issues), 32'd2);
    wb_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      load_ops(40 + c);
      tick();
    end
    req_valid_i = '0;
    repeat (5) tick();

    // Fill the FIFO, then reset asynchronously between edges.
    wb_ready_i  = 1'b0;
    req_valid_i = '1;
    load_ops(48);
    repeat (4) tick();
    #1 check("full_wb_valid", 32'(wb_valid_o), 32'h1);
    #1 reset_i = 1'b1;
    #1;
    check("async_rst_wb_valid", 32'(wb_valid_o), 32'h0);
    check("async_rst_wb_tag", 32'(wb_tag_o), 32'h0);
    check("async_rst_wb_value", wb_value_o, 32'h0);
    check("async_rst_grant", 32'(req_grant_o), 32'h0);
    check("async_rst_request", 32'(arith_request_o), 32'h0);
    tick();
    reset_i    = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_grant_o), 32'h1);
    check("post_rst_wb_valid", 32'(wb_valid_o), 32'h0);
    tick();
    req_valid_i = '0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
